// File: rtl/playback_addr_ctrl_pkg.sv
// Shared constants for the playback address controller.
// FSM state encodings and default widths.
package playback_addr_ctrl_pkg;

  localparam int BIT_SZ_DEF = 10;
  localparam int DIV_SZ_DEF = 16;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

endpackage

// File: rtl/playback_addr_ctrl_if.sv
// Control/status bundle between register logic and the controller.
// master drives requests and settings, slave returns address and status.
interface playback_addr_ctrl_if #(
    parameter int BIT_SZ = 10,
    parameter int DIV_SZ = 16
);

    logic              start;
    logic              stop;
    logic              loop;
    logic [BIT_SZ-1:0] start_addr;
    logic [BIT_SZ-1:0] end_addr;
    logic [DIV_SZ-1:0] rate_div;
    logic [BIT_SZ-1:0] address;
    logic              addr_valid;
    logic              busy;
    logic              done;

    modport master (
        output start, stop, loop,
        output start_addr, end_addr, rate_div,
        input  address, addr_valid, busy, done
    );

    modport slave (
        input  start, stop, loop,
        input  start_addr, end_addr, rate_div,
        output address, addr_valid, busy, done
    );

endinterface

// File: rtl/playback_addr_ctrl_tick_divider.sv
// Rate divider: counts 0..terminal while enabled, ticks on terminal.
// Clear forces the count back to zero and wins over enable.
module playback_addr_ctrl_tick_divider #(
    parameter int DIV_SZ = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              enable,
    input  logic [DIV_SZ-1:0] terminal,
    output logic              tick
);

    logic [DIV_SZ-1:0] count;

    assign tick = enable && (count == terminal);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + DIV_SZ'(1);
        end
    end

endmodule

// File: rtl/playback_addr_ctrl.sv
// Steps a read address through [start_addr..end_addr] at a set rate,
// single-shot or looped, with start/stop control and busy/done status.
module playback_addr_ctrl
    import playback_addr_ctrl_pkg::*;
#(
    parameter int BIT_SZ = BIT_SZ_DEF,
    parameter int DIV_SZ = DIV_SZ_DEF
) (
    input  logic                 clock,
    input  logic                 reset_n,
    playback_addr_ctrl_if.slave  bus
);

    state_t            state;
    state_t            state_nxt;
    logic [BIT_SZ-1:0] start_r;
    logic [BIT_SZ-1:0] end_r;
    logic [DIV_SZ-1:0] rate_r;
    logic              loop_r;
    logic [BIT_SZ-1:0] address;
    logic              addr_valid;
    logic              running;
    logic              accept;
    logic              tick;
    logic              step;
    logic              at_end;

    assign running = (state == RUN);
    assign accept  = !running && (state != 2'd3)
                   && bus.start && !bus.stop;
    assign step    = running && tick && !bus.stop;
    assign at_end  = (address == end_r);

    playback_addr_ctrl_tick_divider #(
        .DIV_SZ   (DIV_SZ)
    ) u_div (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (!running || bus.stop),
        .enable   (running),
        .terminal (rate_r),
        .tick     (tick)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = RUN;
            RUN: begin
                if (bus.stop) begin
                    state_nxt = IDLE;
                end else if (tick && at_end && !loop_r) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.stop) begin
                    state_nxt = IDLE;
                end else if (accept) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy       = running;
        bus.done       = (state == DONE);
        bus.address    = address;
        bus.addr_valid = addr_valid;
    end

    // Settings are frozen for the whole run once a start is accepted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            start_r <= '0;
            end_r   <= '0;
            rate_r  <= '0;
            loop_r  <= 1'b0;
        end else if (accept) begin
            start_r <= bus.start_addr;
            end_r   <= bus.end_addr;
            rate_r  <= bus.rate_div;
            loop_r  <= bus.loop;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            address    <= '0;
            addr_valid <= 1'b0;
        end else if (accept) begin
            address    <= bus.start_addr;
            addr_valid <= 1'b1;
        end else if (step && !at_end) begin
            address    <= address + BIT_SZ'(1);
            addr_valid <= 1'b1;
        end else if (step && loop_r) begin
            address    <= start_r;
            addr_valid <= 1'b1;
        end else begin
            addr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_playback_addr_ctrl.sv
// Directed bench for playback_addr_ctrl.
// Each check packs {address, addr_valid, busy, done}.
module tb_playback_addr_ctrl;

    logic clock;
    logic reset_n;
    int   passed;
    int   total;

    playback_addr_ctrl_if #(.BIT_SZ(10), .DIV_SZ(16)) bus ();

    playback_addr_ctrl #(
        .BIT_SZ  (10),
        .DIV_SZ  (16)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic setup(input logic [9:0] sa, input logic [9:0] ea,
                         input logic [15:0] rd, input logic lp);
        bus.start_addr = sa;
        bus.end_addr   = ea;
        bus.rate_div   = rd;
        bus.loop       = lp;
    endtask

    task automatic test_reset();
        logic [12:0] obs;
        reset_n = 1'b0;
        step();
        step();
        obs = {bus.address, bus.addr_valid, bus.busy, bus.done};
        total++;
        if (obs !== 13'h0)
            $display("FAIL reset_state got %h want %h", obs, 13'h0);
        else passed++;
        reset_n = 1'b1;
        step();
        setup(10'd300, 10'd400, 16'd0, 1'b1);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        obs = {bus.address, bus.addr_valid, bus.busy, bus.done};
        total++;
        if (obs !== {10'd302, 1'b1, 1'b1, 1'b0})
            $display("FAIL reset_prerun got %h", obs);
        else passed++;
        #2;
        reset_n = 1'b0;
        #1;
        obs = {bus.address, bus.addr_valid, bus.busy, bus.done};
        total++;
        if (obs !== 13'h0)
            $display("FAIL reset_async got %h want %h", obs, 13'h0);
        else passed++;
        step();
        step();
        obs = {bus.address, bus.addr_valid, bus.busy, bus.done};
        total++;
        if (obs !== 13'h0)
            $display("FAIL reset_hold got %h want %h", obs, 13'h0);
        else passed++;
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_single_shot();
        logic [12:0] obs;
        logic [9:0]  seq [4];
        seq = '{10'd5, 10'd6, 10'd7, 10'd8};
        setup(10'd5, 10'd8, 16'd0, 1'b0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            obs = {bus.address, bus.addr_valid, bus.busy, bus.done};
            total++;
            if (obs !== {seq[i], 1'b1, 1'b1, 1'b0})
                $display("FAIL single_seq%0d got %h want addr %0d",
                         i, obs, seq[i]);
            else passed++;
            step();
        end
        obs = {bus.address, bus.addr_valid, bus.busy, bus.done};
        total++;
        if (obs !== {10'd8, 1'b0, 1'b0, 1'b1})
            $display("FAIL single_done got %h", obs);
        else passed++;
    endtask

    task automatic test_loop_rate();
        logic [12:0] obs;
        logic [9:0]  seq [5];
        seq = '{10'd0, 10'd1, 10'd2, 10'd0, 10'd1};
        setup(10'd0, 10'd2, 16'd3, 1'b1);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 4; j++) begin
                obs = {bus.address, bus.addr_valid, bus.busy, bus.done};
                total++;
                if (obs !== {seq[i], j == 0, 1'b1, 1'b0})
                    $display("FAIL loop_s%0d_c%0d got %h want addr %0d",
                             i, j, obs, seq[i]);
                else passed++;
                if (!(i == 4 && j == 0)) step();
                else break;
            end
        end
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        obs = {bus.address, bus.addr_valid, bus.busy, bus.done};
        total++;
        if (obs !== {10'd1, 1'b0, 1'b0, 1'b0})
            $display("FAIL loop_stop got %h", obs);
        else passed++;
        step();
        obs = {bus.address, bus.addr_valid, bus.busy, bus.done};
        total++;
        if (obs !== {10'd1, 1'b0, 1'b0, 1'b0})
            $display("FAIL loop_idle got %h", obs);
        else passed++;
    endtask

    task automatic test_wrap();
        logic [12:0] obs;
        logic [9:0]  seq [4];
        seq = '{10'd1022, 10'd1023, 10'd0, 10'd1};
        setup(10'd1022, 10'd1, 16'd0, 1'b0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            obs = {bus.address, bus.addr_valid, bus.busy, bus.done};
            total++;
            if (obs !== {seq[i], 1'b1, 1'b1, 1'b0})
                $display("FAIL wrap_seq%0d got %h want addr %0d",
                         i, obs, seq[i]);
            else passed++;
            step();
        end
        obs = {bus.address, bus.addr_valid, bus.busy, bus.done};
        total++;
        if (obs !== {10'd1, 1'b0, 1'b0, 1'b1})
            $display("FAIL wrap_done got %h", obs);
        else passed++;
    endtask

    task automatic test_start_stop();
        logic [12:0] obs;
        bus.stop = 1'b1;
        step();
        obs = {bus.address, bus.addr_valid, bus.busy, bus.done};
        total++;
        if (obs !== {10'd1, 1'b0, 1'b0, 1'b0})
            $display("FAIL stop_done_clear got %h", obs);
        else passed++;
        setup(10'd50, 10'd60, 16'd0, 1'b1);
        bus.start = 1'b1;
        step();
        obs = {bus.address, bus.addr_valid, bus.busy, bus.done};
        total++;
        if (obs !== {10'd1, 1'b0, 1'b0, 1'b0})
            $display("FAIL start_stop_same got %h", obs);
        else passed++;
        bus.stop = 1'b0;
        setup(10'd10, 10'd12, 16'd1, 1'b0);
        step();
        setup(10'd100, 10'd200, 16'd0, 1'b1);
        obs = {bus.address, bus.addr_valid, bus.busy, bus.done};
        total++;
        if (obs !== {10'd10, 1'b1, 1'b1, 1'b0})
            $display("FAIL run_first got %h", obs);
        else passed++;
        step();
        step();
        bus.start = 1'b0;
        obs = {bus.address, bus.addr_valid, bus.busy, bus.done};
        total++;
        if (obs !== {10'd11, 1'b1, 1'b1, 1'b0})
            $display("FAIL run_ignore_start got %h", obs);
        else passed++;
        step();
        step();
        obs = {bus.address, bus.addr_valid, bus.busy, bus.done};
        total++;
        if (obs !== {10'd12, 1'b1, 1'b1, 1'b0})
            $display("FAIL run_last got %h", obs);
        else passed++;
        step();
        step();
        obs = {bus.address, bus.addr_valid, bus.busy, bus.done};
        total++;
        if (obs !== {10'd12, 1'b0, 1'b0, 1'b1})
            $display("FAIL run_done got %h", obs);
        else passed++;
    endtask

    task automatic test_single_addr();
        logic [12:0] obs;
        setup(10'd7, 10'd7, 16'd2, 1'b0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            obs = {bus.address, bus.addr_valid, bus.busy, bus.done};
            total++;
            if (obs !== {10'd7, j == 0, 1'b1, 1'b0})
                $display("FAIL one_addr_c%0d got %h", j, obs);
            else passed++;
            step();
        end
        obs = {bus.address, bus.addr_valid, bus.busy, bus.done};
        total++;
        if (obs !== {10'd7, 1'b0, 1'b0, 1'b1})
            $display("FAIL one_addr_done got %h", obs);
        else passed++;
    endtask

    initial begin
        passed   = 0;
        total    = 0;
        reset_n  = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        setup(10'd0, 10'd0, 16'd0, 1'b0);
        test_reset();
        test_single_shot();
        test_loop_rate();
        test_wrap();
        test_start_stop();
        test_single_addr();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
